mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and its data (MEM-stage) port.
- Runs a grant/access/response state machine with configurable memory wait states and a starvation guard for fetch.
- Generates per-port stall signals so the hazard and stall logic can freeze the affected pipeline registers.
- Sits between the IF/MEM stages and the memory model, replacing the separate instruction and data memories.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_addr, mem_wdata, mem_we,
           stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_addr, mem_wdata, mem_we,
           stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional macro MEMARB_RR_EN swaps DM priority + starvation guard for round-robin.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate pending requests
// ACCESS | winner's request latched; count memory wait states
// RESP   | owner's ack pulses for one cycle
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_dm_q, owner_dm_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        grant_dm;
  logic        mem_we_c, if_ack_c, dm_ack_c;

`ifdef MEMARB_RR_EN
  logic last_dm_q, last_dm_d;

  // Whichever port was not granted last wins a conflict.
  assign grant_dm = bus.dm_req & (~bus.if_req | ~last_dm_q);
`else
  localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  assign grant_dm = bus.dm_req & (~bus.if_req | (starve_q != STARVE_C));
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mem_we_c   = 1'b0;
    if_ack_c   = 1'b0;
    dm_ack_c   = 1'b0;
`ifdef MEMARB_RR_EN
    last_dm_d  = last_dm_q;
`else
    starve_d   = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.if_req | bus.dm_req) begin
          state_d    = ACCESS;
          cnt_d      = 4'd0;
          owner_dm_d = grant_dm;
          we_d       = grant_dm & bus.dm_we;
          addr_d     = grant_dm ? bus.dm_addr : bus.if_addr;
          wdata_d    = grant_dm ? bus.dm_wdata : wdata_q;
`ifdef MEMARB_RR_EN
          last_dm_d  = grant_dm;
`else
          if (!grant_dm) begin
            starve_d = 4'd0;
          end else if (bus.if_req && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
          end
`endif
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_C) begin
          mem_we_c = we_q & owner_dm_q;
          state_d  = RESP;
          if (!owner_dm_q) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP: begin
        if_ack_c = ~owner_dm_q;
        dm_ack_c = owner_dm_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      owner_dm_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEMARB_RR_EN
      last_dm_q  <= 1'b0;
`else
      starve_q   <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEMARB_RR_EN
      last_dm_q  <= last_dm_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  // mem_we is decoded from state, so an async reset drops it at once.
  assign bus.mem_we    = mem_we_c;
  assign bus.if_ack    = if_ack_c;
  assign bus.dm_ack    = dm_ack_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_c;
  assign bus.stall_mem = bus.dm_req & ~dm_ack_c;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random rounds checked against
// a transaction-level model (shadow memory, arbitration rule, fixed access latency).
module tb_mem_port_arbiter;
  localparam int WAIT  = 1;
  localparam int SLIM  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.WAIT_CYCLES(WAIT), .STARVE_LIMIT(SLIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  int          starve_m  = 0;
  bit          last_dm_m = 1'b0;
  logic [31:0] last_dm   = '0;
  logic [31:0] last_if   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic bit pick_dm(input bit ip, input bit dp);
    if (!dp) return 1'b0;
    if (!ip) return 1'b1;
`ifdef MEMARB_RR_EN
    return !last_dm_m;
`else
    return starve_m != SLIM;
`endif
  endfunction

  task automatic note_grant(input bit dm, input bit ip);
    if (!dm) starve_m = 0;
    else if (ip && starve_m < 15) starve_m++;
    last_dm_m = dm;
  endtask

  // One IF request (optional) and n back-to-back DM requests, all with fixed operands.
  task automatic serve(input bit ip, input logic [31:0] ia, input int n, input bit dw,
                       input logic [31:0] da, input logic [31:0] dd);
    bit if_p;
    int dm_left;
    bit exp_dm;
    int since;
    bit first;
    int we_cnt;
    int lat;
    bit ack_now;
    if_p = ip;
    dm_left = n;
    if (!if_p && dm_left == 0) return;
    bus.if_req = ip; bus.if_addr = ia;
    bus.dm_req = (n > 0); bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dd;
    exp_dm = pick_dm(if_p, dm_left > 0);
    note_grant(exp_dm, if_p);
    since = 0; first = 1'b1; we_cnt = 0;
    while (if_p || dm_left > 0) begin
      @(negedge clk);
      since++;
      if (bus.mem_we) we_cnt++;
      lat = first ? WAIT + 2 : WAIT + 3;
      ack_now = (since == lat);
      chk("if_ack", bus.if_ack, ack_now & !exp_dm);
      chk("dm_ack", bus.dm_ack, ack_now & exp_dm);
      chk("stall_if", bus.stall_if, if_p & !(ack_now & !exp_dm));
      chk("stall_mem", bus.stall_mem, (dm_left > 0) & !(ack_now & exp_dm));
      if (ack_now) begin
        if (exp_dm) begin
          chk("mem_addr_dm", bus.mem_addr, da);
          if (dw) begin
            ref_mem[idx(da)] = dd;
            chk("we_pulses_st", we_cnt, 1);
            chk("mem_wdata", bus.mem_wdata, dd);
          end else begin
            last_dm = ref_mem[idx(da)];
            chk("we_pulses_ld", we_cnt, 0);
          end
          chk("dm_rdata", bus.dm_rdata, last_dm);
          dm_left--;
          bus.dm_req = (dm_left > 0);
        end else begin
          last_if = ref_mem[idx(ia)];
          chk("mem_addr_if", bus.mem_addr, ia);
          chk("we_pulses_if", we_cnt, 0);
          chk("if_rdata", bus.if_rdata, last_if);
          if_p = 1'b0;
          bus.if_req = 1'b0;
        end
        since = 0; first = 1'b0; we_cnt = 0;
        if (if_p || dm_left > 0) begin
          exp_dm = pick_dm(if_p, dm_left > 0);
          note_grant(exp_dm, if_p);
        end
      end
    end
    @(negedge clk);
    chk("busy_idle", bus.busy, 1'b0);
    chk("if_rdata_hold", bus.if_rdata, last_if);
    chk("dm_rdata_hold", bus.dm_rdata, last_dm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[16] = 32'h2008_0005;
    ref_mem[16] = 32'h2008_0005;

    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_if_ack", bus.if_ack, 1'b0);
    chk("rst_dm_ack", bus.dm_ack, 1'b0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);

    serve(1'b1, 32'h40, 0, 1'b0, '0, '0);
    serve(1'b0, '0, 1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    serve(1'b0, '0, 1, 1'b0, 32'h10, '0);
    chk("load_after_store", bus.dm_rdata, 32'hDEAD_BEEF);
    serve(1'b1, 32'h44, 1, 1'b0, 32'h80, '0);
    serve(1'b1, 32'h48, 6, 1'b0, 32'h84, '0);
    serve(1'b1, 32'h4C, 5, 1'b0, 32'h88, '0);
    serve(1'b0, '0, 1, 1'b1, 32'h20, 32'h0BAD_F00D);

    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'h1234_5678;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_we) got = 1'b1;
    end
    chk("rst_we_seen", got, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", bus.mem_we, 1'b0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_ack", bus.dm_ack, 1'b0);
    bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_noack", bus.dm_ack, 1'b0);
    chk("rst_mem_kept", mem[idx(32'h20)], ref_mem[idx(32'h20)]);
    reset = 1'b0;
    starve_m = 0; last_dm_m = 1'b0; last_dm = '0; last_if = '0;
    chk("rst_mid_ifrd", bus.if_rdata, 32'h0);
    serve(1'b1, 32'h40, 0, 1'b0, '0, '0);

    for (int r = 0; r < 40; r++) begin
      bit          ip;
      int          n;
      bit          dw;
      logic [31:0] ia, da, dd;
      ip = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(0, 3));
      dw = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; dd = $urandom;
      serve(ip, ia, n, dw, da, dd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
